muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative RV32M/RV64M multiply/divide unit for the EX stage, sitting beside the single-cycle ALU.
- Accepts an M-extension op (funct3 encoding) with two operands and runs a radix-2 shift-add multiply or restoring divide.
- Holds the pipeline with a stall signal until the result is ready.
- Provides the multi-cycle execution path the combinational ALU control/ALU pair cannot.

Parameters:
- XLEN, 32, operand/result width (32 or 64)
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous abort of any in-flight op (branch/trap kill)
- start  input  1  EX holds a valid M-op; held high until done
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  input  XLEN  operand A (dividend / multiplicand)
- rs2  input  XLEN  operand B (divisor / multiplier)
- stall  output  1  combinational: start & (state != DONE)
- busy  output  1  state is CALC or FIX
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  registered result, held until next accept

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, counter=0, all internal regs cleared. Reset mid-op discards the op.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start & !flush, latch funct3, operand magnitudes and sign flags; counter=XLEN.
  - Go to CALC, except fast-path cases, which go directly to DONE with result loaded.
- Fast paths (DONE one cycle after accept):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (DIV/REM, rs1 = -2^(XLEN-1), rs2 = -1): DIV gives rs1; REM gives 0.
- Sign handling:
  - Operands signed for MULH (both), MULHSU (rs1 only), DIV/REM (both); MUL treated as unsigned (low half identical).
  - Magnitudes are taken at accept.
- CALC (exactly XLEN cycles, counter decrements to 0):
  - Multiply: 2*XLEN product register; add multiplicand when multiplier LSB=1; shift right.
  - Divide: restoring; shift remainder left, trial-subtract divisor, set quotient bit if non-negative.
  - At counter=1 go to FIX.
- FIX (1 cycle):
  - Apply sign correction. Product is negated if the operand signs differ. Quotient is negated if the signs differ (DIV). Remainder takes the dividend sign (REM).
  - Select result: MUL = low XLEN bits; MULH* = high XLEN bits; DIV*/REM* = quotient/remainder.
  - Write result; go to DONE.
- DONE (1 cycle): done=1, stall=0 so EX advances; start ignored this cycle (same instruction still visible); go to IDLE.
- Latency (start first high in cycle T):
  - Normal path: done in cycle T+XLEN+2.
  - Fast path: done in cycle T+1.
  - Back-to-back ops: next accept is possible in cycle T+XLEN+3.
- flush:
  - In any state, next state is IDLE, busy=0, and no done pulse; result keeps its old value.
  - flush with start in IDLE: not accepted.
  - flush has priority over start and over FIX/DONE progression.
- stall is combinational and high in the accept cycle itself, so the pipeline freezes without a bubble.
- funct3 change while busy: ignored (latched copy used).
- All arithmetic is XLEN-generic; no width-specific constants other than those derived from XLEN.

Test Plan (XLEN=32):
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start at cycle 0 -> stall 1 in cycles 0..33, done pulse cycle 34, result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MUL -> 0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; each done at cycle 34.
- DIVU 0x12345678 / 0 -> done cycle 1, result 0xFFFFFFFF; REMU -> 0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1; REM -> 0.
- Flush at cycle 10 of a DIV -> busy=0 at cycle 11, no done, result unchanged; a new MUL 3x5 accepted at cycle 11 -> result 15, done at cycle 45.
- rst asserted asynchronously mid-CALC -> busy/done/result immediately 0; start held across the DONE cycle of an op -> exactly one done pulse, no restart.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide. EX is held with a stall until the one-cycle done pulse.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              r_state;
  logic [2:0]          r_funct3;
  logic                r_neg_res;
  logic                r_neg_rem;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opb;

  logic                w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]     w_a_mag, w_b_mag;
  logic                w_div_zero, w_ovf, w_fast;
  logic [XLEN-1:0]     w_fast_res;
  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_next, w_div_next;
  logic [XLEN:0]       w_rem_sh;
  logic [XLEN+1:0]     w_diff;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quo_mag, w_rem_mag, w_quo, w_rem;
  logic [XLEN-1:0]     w_fix_res;

  assign w_is_div   = funct3[2];
  assign w_a_signed = (funct3 == 3'b001) | (funct3 == 3'b010) |
                      (funct3 == 3'b100) | (funct3 == 3'b110);
  assign w_b_signed = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign w_a_neg    = w_a_signed & rs1[XLEN-1];
  assign w_b_neg    = w_b_signed & rs2[XLEN-1];
  assign w_a_mag    = w_a_neg ? -rs1 : rs1;
  assign w_b_mag    = w_b_neg ? -rs2 : rs2;

  assign w_div_zero = w_is_div & (rs2 == '0);
  assign w_ovf      = w_is_div & ~funct3[0] & (rs1 == MIN_NEG) & (rs2 == '1);
  assign w_fast     = w_div_zero | w_ovf;

  always_comb begin
    w_fast_res = '0;
    if (w_div_zero)
      w_fast_res = funct3[1] ? rs1 : '1;
    else if (w_ovf)
      w_fast_res = funct3[1] ? '0 : rs1;
  end

  // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opb};
  assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};

  // Divide: shift {rem, quo} left, trial-subtract divisor, keep difference if non-negative.
  assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_opb};
  assign w_div_next = w_diff[XLEN+1] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

  assign w_prod    = r_neg_res ? -r_acc : r_acc;
  assign w_quo_mag = r_acc[XLEN-1:0];
  assign w_rem_mag = r_acc[2*XLEN-1:XLEN];
  assign w_quo     = r_neg_res ? -w_quo_mag : w_quo_mag;
  assign w_rem     = r_neg_rem ? -w_rem_mag : w_rem_mag;

  always_comb begin
    w_fix_res = '0;
    case (r_funct3)
      3'b000:                 w_fix_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_quo;
      default:                w_fix_res = w_rem;
    endcase
  end

  assign stall = start & (r_state != S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_funct3  <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_funct3  <= funct3;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_cnt     <= CNT_W'(XLEN);
            r_acc     <= w_is_div ? {{XLEN{1'b0}}, w_a_mag} : {{XLEN{1'b0}}, w_b_mag};
            r_opb     <= w_is_div ? w_b_mag : w_a_mag;
            if (w_fast) begin
              result  <= w_fast_res;
              r_state <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_state <= S_CALC;
              busy    <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1))
            r_state <= S_FIX;
        end
        S_FIX: begin
          result  <= w_fix_res;
          r_state <= S_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        default: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (XLEN=32): vector table, random ops
// against a reference model, and hand-written flush/reset/latency sequences.
module tb_muldiv_seq;

  localparam int XLEN = 32;

  logic            clk, rst, flush, start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1, rs2;
  logic            stall, busy, done;
  logic [XLEN-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [XLEN-1:0] sb[$];
  logic [XLEN-1:0] last_exp;

  typedef struct {
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  vec_t vecs[14];

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [63:0] sa, sb64, p;
    logic [63:0] up;
    sa   = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    case (f3)
      3'b000: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      3'b001: begin p = sa * sb64; return p[63:32]; end
      3'b010: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
      3'b011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'b100: begin
        if (b == 0) return '1;
        p = sa / sb64; return p[31:0];
      end
      3'b101: return (b == 0) ? '1 : a / b;
      3'b110: begin
        if (b == 0) return a;
        p = sa % sb64; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp);
    @(posedge clk);
    #1;
    start  = 1'b1;
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    sb.push_back(exp);
  endtask

  // Called in the accept cycle after drive; follows the op until its done pulse.
  task automatic wait_done(input string name, input int lat);
    int cyc;
    bit seen, stall_ok;
    logic [XLEN-1:0] e;
    cyc = 0; seen = 0; stall_ok = 1;
    while (!seen && cyc <= lat + 4) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        if (stall !== 1'b0) stall_ok = 0;
      end else begin
        if (stall !== 1'b1) stall_ok = 0;
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    if (!seen) begin
      chk({name, "_timeout"}, 64'(cyc), 64'(lat));
      if (sb.size() > 0) void'(sb.pop_front());
      start = 1'b0;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      return;
    end
    chk({name, "_latency"}, 64'(cyc), 64'(lat));
    chk({name, "_stall"}, 64'(stall_ok), 64'd1);
    e = sb.pop_front();
    chk({name, "_result"}, 64'(result), 64'(e));
    last_exp = e;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk({name, "_no_restart"}, {62'b0, busy, done}, 64'd0);
  endtask

  initial begin
    logic [2:0]      rf;
    logic [XLEN-1:0] ra, rb, rexp;
    bit              saw_done;
    int              rlat;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 34};
    vecs[2]  = '{3'b011, 32'd7,        32'hFFFFFFFD, 32'h00000006, 34};
    vecs[3]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34};
    vecs[4]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[5]  = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34};
    vecs[6]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vecs[7]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vecs[8]  = '{3'b101, 32'd100,      32'd7,        32'd14,       34};
    vecs[9]  = '{3'b111, 32'd100,      32'd7,        32'd2,        34};
    vecs[10] = '{3'b101, 32'h12345678, 32'd0,        32'hFFFFFFFF, 1};
    vecs[11] = '{3'b111, 32'h12345678, 32'd0,        32'h12345678, 1};
    vecs[12] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[13] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};

    rst = 1'b1; flush = 1'b0; start = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    last_exp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {60'b0, stall, busy, done, |result}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp);
      wait_done($sformatf("vec%0d", i), vecs[i].lat);
    end

    for (int i = 0; i < 10; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i == 4) rb = '0;
      rexp = model(rf, ra, rb);
      rlat = (rf[2] && (rb == 0 || (!rf[0] && ra == 32'h80000000 && rb == '1))) ? 1 : 34;
      drive(rf, ra, rb, rexp);
      wait_done($sformatf("rnd%0d", i), rlat);
    end

    // Flush a divide in cycle 10, then accept a new MUL in cycle 11.
    @(posedge clk);
    #1;
    start = 1'b1; funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd3;
    saw_done = 0;
    for (int c = 0; c < 11; c++) begin
      if (c == 10) flush = 1'b1;
      @(negedge clk);
      if (done) saw_done = 1;
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd5;
    sb.push_back(32'd15);
    #2;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_no_done", {63'b0, saw_done | done}, 64'd0);
    chk("flush_result_kept", 64'(result), 64'(last_exp));
    wait_done("post_flush_mul", 34);

    // Asynchronous reset in the middle of CALC.
    drive(3'b101, 32'd5000, 32'd7, 32'd714);
    repeat (5) @(posedge clk);
    #2;
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_reset", {61'b0, busy, done, |result}, 64'd0);
    sb.delete();
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", {62'b0, busy, done}, 64'd0);

    drive(3'b111, 32'd5000, 32'd7, 32'd2);
    wait_done("after_reset_remu", 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
